// File: rtl/fetch_target_queue_pkg.sv
// Shared defines for the fetch target queue: the fetch block handed from the
// branch predictor to instruction fetch, and the default queue depth.
package fetch_target_queue_pkg;

    localparam int FTQ_DEPTH   = 4;
    localparam int FETCH_WIDTH = 2;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
    } predict_info_t;

    typedef struct packed {
        logic [31:0]                        pc;
        logic [3:0]                         mask;
        predict_info_t [FETCH_WIDTH-1:0]    predict_infos;
    } b_f_pkg_t;

endpackage

// File: rtl/fetch_target_queue_if.sv
// Valid/ready handshake carrying one fetch block per transfer.
interface handshake_if;
    import fetch_target_queue_pkg::*;

    logic     valid;
    logic     ready;
    b_f_pkg_t data;

    modport receiver (input valid, input data, output ready);
    modport sender   (output valid, output data, input ready);

endinterface

// File: rtl/fetch_target_queue.sv
// Circular-buffer queue of fetch blocks between branch predictor and fetch.
// Optional macro FTQ_BYPASS_EN: an empty queue forwards the incoming block in the same cycle.
module fetch_target_queue
    import fetch_target_queue_pkg::*;
#(
    parameter int DEPTH = FTQ_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    handshake_if.receiver           receiver,
    handshake_if.sender             sender,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    b_f_pkg_t         mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             queue_valid;
    logic             enq;
    logic             deq;

    // Explicit wrap so depths that are not powers of two stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign queue_valid    = (count != '0);
    assign receiver.ready = rst_n & !flush_i & (count != FULL_CNT);
    assign count_o        = count;

`ifdef FTQ_BYPASS_EN
    logic bypass;

    // A block forwarded straight through is neither written nor popped from storage.
    assign bypass       = !queue_valid & receiver.valid;
    assign sender.valid = rst_n & !flush_i & (queue_valid | receiver.valid);
    assign sender.data  = queue_valid ? mem[head] : receiver.data;
    assign enq          = receiver.valid & receiver.ready & !(bypass & sender.ready);
    assign deq          = sender.valid & sender.ready & !bypass;
`else
    assign sender.valid = rst_n & !flush_i & queue_valid;
    assign sender.data  = mem[head];
    assign enq          = receiver.valid & receiver.ready;
    assign deq          = sender.valid & sender.ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= ptr_inc(tail);
            if (deq) head <= ptr_inc(head);
            if (enq && !deq) begin
                count <= count + CNT_W'(1);
            end else if (!enq && deq) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= receiver.data;
    end

endmodule

// File: tb/tb_fetch_target_queue.sv
// Directed self-checking bench for fetch_target_queue at DEPTH=4.
module tb_fetch_target_queue;
    import fetch_target_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;
    int pushed;
    int popped;
    int occ;
    int budget;
    logic rdy;
    logic in_v;
    logic exp_rr;
    logic exp_sv;

    handshake_if bp_if ();
    handshake_if fe_if ();

    fetch_target_queue #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .receiver (bp_if),
        .sender   (fe_if),
        .count_o  (count)
    );

    always #5 clk = ~clk;

    function automatic b_f_pkg_t mk_pkg(input logic [31:0] pc);
        b_f_pkg_t p;
        p.pc                      = pc;
        p.mask                    = pc[6:3] ^ 4'ha;
        p.predict_infos[0].valid  = 1'b1;
        p.predict_infos[0].taken  = pc[3];
        p.predict_infos[0].target = pc + 32'h40;
        p.predict_infos[1].valid  = pc[4];
        p.predict_infos[1].taken  = ~pc[3];
        p.predict_infos[1].target = ~pc;
        return p;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic r);
        bp_if.valid = v;
        bp_if.data  = mk_pkg(pc);
        fe_if.ready = r;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed,
                                input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired: observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        bp_if.valid = 1'b0;
        bp_if.data  = mk_pkg(32'h0);
        fe_if.ready = 1'b0;
        #12;
        check_output("rst_count",  128'(count),       128'(0));
        check_output("rst_svalid", 128'(fe_if.valid), 128'(0));
        check_output("rst_rready", 128'(bp_if.ready), 128'(0));
        cycle();
        rst_n = 1'b1;
        #1;
        check_output("rst_rel_rready", 128'(bp_if.ready), 128'(1));
        check_output("rst_rel_count",  128'(count),       128'(0));

        // Two blocks held, then released in order.
        apply_stimulus(1'b1, 32'h1c000000, 1'b0);
        cycle();
        apply_stimulus(1'b1, 32'h1c000008, 1'b0);
        check_output("buf_count1", 128'(count),       128'(1));
        check_output("buf_valid1", 128'(fe_if.valid), 128'(1));
        check_output("buf_data0",  128'(fe_if.data),  128'(mk_pkg(32'h1c000000)));
        cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0);
        check_output("buf_count2", 128'(count), 128'(2));
        cycle();
        check_output("buf_hold2", 128'(count), 128'(2));
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("buf_out0_valid", 128'(fe_if.valid),   128'(1));
        check_output("buf_out0_pc",    128'(fe_if.data.pc), 128'(32'h1c000000));
        cycle();
        check_output("buf_out1_valid", 128'(fe_if.valid),  128'(1));
        check_output("buf_out1_data",  128'(fe_if.data),   128'(mk_pkg(32'h1c000008)));
        cycle();
        check_output("buf_drained",       128'(count),       128'(0));
        check_output("buf_drained_valid", 128'(fe_if.valid), 128'(0));

        // Fill to capacity; a fifth block waits until a slot frees.
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, 32'h1c000100 + 32'(8 * k), 1'b0);
            cycle();
        end
        apply_stimulus(1'b1, 32'h1c000120, 1'b0);
        check_output("full_count",  128'(count),       128'(4));
        check_output("full_rready", 128'(bp_if.ready), 128'(0));
        check_output("full_svalid", 128'(fe_if.valid), 128'(1));
        cycle();
        check_output("full_hold_count",  128'(count),       128'(4));
        check_output("full_hold_rready", 128'(bp_if.ready), 128'(0));
        apply_stimulus(1'b1, 32'h1c000120, 1'b1);
        check_output("full_pop_rready", 128'(bp_if.ready),   128'(0));
        check_output("full_pop_pc",     128'(fe_if.data.pc), 128'(32'h1c000100));
        cycle();
        apply_stimulus(1'b1, 32'h1c000120, 1'b0);
        check_output("full_after_pop_rready", 128'(bp_if.ready), 128'(1));
        check_output("full_after_pop_count",  128'(count),       128'(3));
        cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("full_fifth_in", 128'(count), 128'(4));
        for (int k = 0; k < 4; k++) begin
            check_output("full_drain_pc", 128'(fe_if.data.pc), 128'(32'h1c000108 + 32'(8 * k)));
            cycle();
        end
        check_output("full_drained", 128'(count), 128'(0));

        // Flush with three queued and a fourth offered.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 32'h1c000200 + 32'(8 * k), 1'b0);
            cycle();
        end
        apply_stimulus(1'b1, 32'h1c000218, 1'b0);
        flush = 1'b1;
        #1;
        check_output("flush_svalid", 128'(fe_if.valid), 128'(0));
        check_output("flush_rready", 128'(bp_if.ready), 128'(0));
        check_output("flush_count",  128'(count),       128'(3));
        cycle();
        flush = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("post_flush_count",  128'(count),       128'(0));
        check_output("post_flush_svalid", 128'(fe_if.valid), 128'(0));
        apply_stimulus(1'b1, 32'h1c000300, 1'b0);
        cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("post_flush_pc",    128'(fe_if.data.pc), 128'(32'h1c000300));
        check_output("post_flush_count1", 128'(count),        128'(1));
        cycle();
        check_output("post_flush_empty", 128'(count), 128'(0));

        // Twelve back-to-back pushes with random back-pressure, tracked by a small model.
        pushed = 0;
        popped = 0;
        occ    = 0;
        budget = 0;
        while (popped < 12 && budget < 300) begin
            rdy  = 1'($urandom_range(0, 1));
            in_v = (pushed < 12);
            apply_stimulus(in_v, 32'h1c000000 + 32'(8 * pushed), rdy);
            exp_rr = (occ != 4);
`ifdef FTQ_BYPASS_EN
            exp_sv = (occ != 0) || in_v;
`else
            exp_sv = (occ != 0);
`endif
            check_output("wrap_rready", 128'(bp_if.ready), 128'(exp_rr));
            check_output("wrap_svalid", 128'(fe_if.valid), 128'(exp_sv));
            check_output("wrap_count",  128'(count),       128'(occ));
            if (exp_sv) begin
                check_output("wrap_pc", 128'(fe_if.data.pc), 128'(32'h1c000000 + 32'(8 * popped)));
            end
            if (in_v && exp_rr) pushed++;
            if (exp_sv && rdy) popped++;
            occ = pushed - popped;
            cycle();
            budget++;
        end
        check_output("wrap_popped", 128'(popped), 128'(12));
        check_output("wrap_pushed", 128'(pushed), 128'(12));

        // Push into an empty queue with the consumer ready.
        apply_stimulus(1'b1, 32'h1c000040, 1'b1);
`ifdef FTQ_BYPASS_EN
        check_output("byp_svalid", 128'(fe_if.valid),   128'(1));
        check_output("byp_pc",     128'(fe_if.data.pc), 128'(32'h1c000040));
        check_output("byp_count",  128'(count),         128'(0));
        cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("byp_after_count",  128'(count),       128'(0));
        check_output("byp_after_svalid", 128'(fe_if.valid), 128'(0));
`else
        check_output("byp_svalid", 128'(fe_if.valid), 128'(0));
        check_output("byp_count",  128'(count),       128'(0));
        cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("byp_late_svalid", 128'(fe_if.valid),   128'(1));
        check_output("byp_late_pc",     128'(fe_if.data.pc), 128'(32'h1c000040));
        check_output("byp_late_count",  128'(count),         128'(1));
        cycle();
        check_output("byp_drained", 128'(count), 128'(0));
`endif

        // Asynchronous reset in the middle of operation.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b1, 32'h1c000500 + 32'(8 * k), 1'b0);
            cycle();
        end
        apply_stimulus(1'b1, 32'h1c000518, 1'b0);
        check_output("mid_rst_pre_count", 128'(count), 128'(3));
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_count",  128'(count),       128'(0));
        check_output("mid_rst_svalid", 128'(fe_if.valid), 128'(0));
        check_output("mid_rst_rready", 128'(bp_if.ready), 128'(0));
        cycle();
        cycle();
        apply_stimulus(1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_output("mid_rst_rel_rready", 128'(bp_if.ready), 128'(1));
        check_output("mid_rst_rel_count",  128'(count),       128'(0));
        apply_stimulus(1'b1, 32'h1c000600, 1'b0);
        cycle();
        apply_stimulus(1'b0, 32'h0, 1'b1);
        check_output("mid_rst_first_data", 128'(fe_if.data), 128'(mk_pkg(32'h1c000600)));
        check_output("mid_rst_count1",     128'(count),      128'(1));
        cycle();
        check_output("mid_rst_empty", 128'(count), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_target_queue.md
FETCH_TARGET_QUEUE -- requirements
Module: fetch_target_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered b_f_pkg_t entries; legal range 2..16.
REQ-002 Port: clk  input  1  single clock; all state changes on posedge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: flush_i  input  1  backend redirect; discards all queued fetch blocks.
REQ-005 Port: receiver  handshake_if.receiver  b_f_pkg_t  fetch blocks from the branch predictor (valid in, ready out, data in).
REQ-006 Port: sender  handshake_if.sender  b_f_pkg_t  fetch blocks to the instruction fetch stage (valid out, ready in, data out).
REQ-007 Port: count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-008 The block SHALL be a circular buffer of DEPTH b_f_pkg_t entries with head (read) pointer, tail (write) pointer and occupancy counter.
REQ-009 Enqueue SHALL occur when receiver.valid & receiver.ready; the entry SHALL be written at tail, and tail SHALL advance.
REQ-010 Dequeue SHALL occur when sender.valid & sender.ready; head SHALL advance.
REQ-011 receiver.ready SHALL be (count != DEPTH) & !flush_i, with no combinational dependence on sender.ready.
REQ-012 sender.valid SHALL be (count != 0) & !flush_i; sender.data SHALL be the entry at head, unless REQ-019 applies.
REQ-013 Pointers SHALL wrap from DEPTH-1 to 0 for any legal DEPTH, including DEPTH values that are not powers of two.
REQ-014 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-015 flush_i SHALL take priority over enqueue and dequeue. In the flush cycle, no write and no dequeue SHALL occur. In the next cycle, count, head and tail SHALL all be 0.
REQ-016 Output order SHALL equal input order; pc, mask and predict_infos SHALL pass through bit-exact.
REQ-017 Minimum latency from enqueue to sender.valid SHALL be 1 cycle; throughput SHALL be 1 entry/cycle in steady state.

Reset
REQ-018 While rst_n=0, the following SHALL hold asynchronously: head=0, tail=0, count=0, count_o=0, sender.valid=0, receiver.ready=0. After deassertion, receiver.ready SHALL be 1. Storage contents SHALL NOT be reset.

Configuration
REQ-019 With FTQ_BYPASS_EN defined:
- When count==0, receiver.valid=1 and !flush_i, then sender.valid SHALL be 1 and sender.data SHALL be receiver.data in the same cycle.
- If sender.ready is also 1, no entry SHALL be written and count SHALL stay 0.
- Otherwise, the entry SHALL be enqueued normally.
REQ-020 Without FTQ_BYPASS_EN, no combinational path from receiver to sender SHALL exist; latency per REQ-017.

Structure
REQ-021 b_f_pkg_t, predict_info_t and the default constant FTQ_DEPTH SHALL reside in the shared defines package; no new typedefs are local to this module.
REQ-022 No sub-module; storage, pointers and counter SHALL be inline (distributed RAM style acceptable).

Verification (DEPTH=4)
REQ-023 Reset:
- Stimulus: assert rst_n=0 mid-operation with count=3.
- Response: immediately count_o=0 and sender.valid=0; after release, receiver.ready=1.
REQ-024 Buffering:
- Stimulus: with sender.ready=0, push pc 0x1c000000 then 0x1c000008; then set sender.ready=1.
- Response: count_o=2 while held; outputs 0x1c000000 then 0x1c000008 on consecutive cycles; count_o then 0.
REQ-025 Full:
- Stimulus: with sender.ready=0, push 4 entries; present a 5th with valid held high; pop one entry.
- Response: after the 4th push, count_o=4 and receiver.ready=0; the 5th is held, not lost; the cycle after the pop, receiver.ready=1 and the 5th is accepted.
REQ-026 Flush:
- Stimulus: with count=3, assert flush_i for one cycle while receiver.valid=1.
- Response: that cycle sender.valid=0 and receiver.ready=0; next cycle count_o=0; the pushed entry never appears at the output.
REQ-027 Wrap:
- Stimulus: 12 back-to-back pushes of pc 0x1c000000+8k with random sender.ready.
- Response: all 12 entries output in order; none duplicated or dropped.
REQ-028 Bypass:
- Stimulus: empty queue, sender.ready=1, push pc 0x1c000040.
- Response with FTQ_BYPASS_EN: same-cycle sender.data.pc=0x1c000040 and count_o stays 0.
- Response without FTQ_BYPASS_EN: it appears one cycle later.
